// File: rtl/writeback_regfile_if.sv
// ============================================================================
// Module   : writeback_regfile_if
// Purpose  : Memory-stage inputs, decode read ports and W-stage outputs of the
//            writeback / register-file block, bundled with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_regfile_if;
  logic [3:0]  m_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] m_valM;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  stat;
  logic        halted;

  modport master (
    output m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM,
    output W_stall, W_bubble, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    input  stat, halted
  );

  modport slave (
    input  m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM,
    input  W_stall, W_bubble, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    output stat, halted
  );
endinterface

`default_nettype wire

// File: rtl/writeback_regfile.sv
// ============================================================================
// Module   : writeback_regfile
// Purpose  : Pipeline W register, 15 x 64-bit register file and RUN/HALT
//            status machine. Define WB_BYPASS_EN for write-before-read reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_regfile (
  input logic                  clk,
  input logic                  rst_n,
  writeback_regfile_if.slave   bus
);

  localparam int         C_NUM_REGS  = 15;
  localparam logic [3:0] C_STAT_AOK  = 4'd1;
  localparam logic [3:0] C_ICODE_NOP = 4'h1;
  localparam logic [3:0] C_RNONE     = 4'hF;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_run;

  logic [3:0]  r_w_stat;
  logic [3:0]  r_w_icode;
  logic [3:0]  r_w_dstE;
  logic [3:0]  r_w_dstM;
  logic [63:0] r_w_valE;
  logic [63:0] r_w_valM;
  logic [3:0]  r_halt_stat;

  logic                            w_wr_en;
  logic [C_NUM_REGS-1:0][63:0]     w_regs;
  logic [63:0]                     w_rvalA;
  logic [63:0]                     w_rvalB;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    case (r_state)
      S_RUN: begin
        w_run = 1'b1;
        if (r_w_stat != C_STAT_AOK) begin
          w_state_next = S_HALT;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  // Status reported while halted is the one that caused the halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt_stat <= C_STAT_AOK;
    end else if (w_run && (r_w_stat != C_STAT_AOK)) begin
      r_halt_stat <= r_w_stat;
    end
  end

  // ------------------------------------------------------------ W register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_stat  <= C_STAT_AOK;
      r_w_icode <= C_ICODE_NOP;
      r_w_dstE  <= C_RNONE;
      r_w_dstM  <= C_RNONE;
      r_w_valE  <= '0;
      r_w_valM  <= '0;
    end else if (w_run && !bus.W_stall) begin
      if (bus.W_bubble) begin
        r_w_stat  <= C_STAT_AOK;
        r_w_icode <= C_ICODE_NOP;
        r_w_dstE  <= C_RNONE;
        r_w_dstM  <= C_RNONE;
        r_w_valE  <= '0;
        r_w_valM  <= '0;
      end else begin
        r_w_stat  <= bus.m_stat;
        r_w_icode <= bus.M_icode;
        r_w_dstE  <= bus.M_dstE;
        r_w_dstM  <= bus.M_dstM;
        r_w_valE  <= bus.M_valE;
        r_w_valM  <= bus.m_valM;
      end
    end
  end

  // A faulting instruction never commits, and nothing commits once halted.
  assign w_wr_en = w_run && (r_w_stat == C_STAT_AOK);

  // --------------------------------------------------------- register file
  // RNONE (4'hF) never matches a register index, so it needs no extra gating.
  for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
    logic        w_hit_e;
    logic        w_hit_m;
    logic [63:0] r_q;

    assign w_hit_e = w_wr_en && (r_w_dstE == 4'(gi));
    assign w_hit_m = w_wr_en && (r_w_dstM == 4'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_hit_m) begin
        r_q <= r_w_valM;
      end else if (w_hit_e) begin
        r_q <= r_w_valE;
      end
    end

    assign w_regs[gi] = r_q;
  end

  function automatic logic [63:0] read_stored(
    input logic [3:0]                   src,
    input logic [C_NUM_REGS-1:0][63:0]  regs
  );
    logic [63:0] val;
    val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (src == 4'(i)) begin
        val = regs[i];
      end
    end
    return val;
  endfunction

  always_comb begin
    w_rvalA = read_stored(bus.d_srcA, w_regs);
    w_rvalB = read_stored(bus.d_srcB, w_regs);
`ifdef WB_BYPASS_EN
    // Forward the value committing at the coming edge; M port has priority.
    if (w_wr_en && (bus.d_srcA != C_RNONE)) begin
      if (bus.d_srcA == r_w_dstM) begin
        w_rvalA = r_w_valM;
      end else if (bus.d_srcA == r_w_dstE) begin
        w_rvalA = r_w_valE;
      end
    end
    if (w_wr_en && (bus.d_srcB != C_RNONE)) begin
      if (bus.d_srcB == r_w_dstM) begin
        w_rvalB = r_w_valM;
      end else if (bus.d_srcB == r_w_dstE) begin
        w_rvalB = r_w_valE;
      end
    end
`endif
  end

  // --------------------------------------------------------------- outputs
  assign bus.d_rvalA = w_rvalA;
  assign bus.d_rvalB = w_rvalB;
  assign bus.W_icode = r_w_icode;
  assign bus.W_dstE  = r_w_dstE;
  assign bus.W_dstM  = r_w_dstM;
  assign bus.W_valE  = r_w_valE;
  assign bus.W_valM  = r_w_valM;
  assign bus.stat    = (r_state == S_HALT) ? r_halt_stat : r_w_stat;
  assign bus.halted  = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Directed and randomized checks of writeback_regfile against a
//            cycle-level reference model. Honors WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_writeback_regfile;

  logic clk;
  logic rst_n;
  int   n_vectors;
  int   n_miscompares;

  writeback_regfile_if bus ();

  writeback_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b1;
  always #10 clk = ~clk;

  // Reference state: architectural registers plus the W stage contents.
  logic [63:0] m_reg [15];
  logic [3:0]  mw_stat, mw_icode, mw_dstE, mw_dstM;
  logic [63:0] mw_valE, mw_valM;
  logic        m_halted;
  logic [3:0]  m_halt_stat;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] src);
    logic [63:0] v;
    if (src == 4'hF) return 64'd0;
    v = m_reg[src];
`ifdef WB_BYPASS_EN
    if (!m_halted && mw_stat == 4'd1) begin
      if (mw_dstM == src)      v = mw_valM;
      else if (mw_dstE == src) v = mw_valE;
    end
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = '0;
    mw_stat = 4'd1; mw_icode = 4'h1; mw_dstE = 4'hF; mw_dstM = 4'hF;
    mw_valE = '0;   mw_valM = '0;
    m_halted = 1'b0; m_halt_stat = 4'd1;
  endtask

  task automatic model_edge();
    if (m_halted) return;
    if (mw_stat == 4'd1) begin
      if (mw_dstE != 4'hF) m_reg[mw_dstE] = mw_valE;
      if (mw_dstM != 4'hF) m_reg[mw_dstM] = mw_valM;
    end else begin
      m_halted    = 1'b1;
      m_halt_stat = mw_stat;
    end
    if (!bus.W_stall) begin
      if (bus.W_bubble) begin
        mw_stat = 4'd1; mw_icode = 4'h1; mw_dstE = 4'hF; mw_dstM = 4'hF;
        mw_valE = '0;   mw_valM = '0;
      end else begin
        mw_stat = bus.m_stat; mw_icode = bus.M_icode;
        mw_dstE = bus.M_dstE; mw_dstM  = bus.M_dstM;
        mw_valE = bus.M_valE; mw_valM  = bus.m_valM;
      end
    end
  endtask

  task automatic check_outputs();
    check_value("stat",    64'(bus.stat),    64'(m_halted ? m_halt_stat : mw_stat));
    check_value("halted",  64'(bus.halted),  64'(m_halted));
    check_value("W_icode", 64'(bus.W_icode), 64'(mw_icode));
    check_value("W_dstE",  64'(bus.W_dstE),  64'(mw_dstE));
    check_value("W_dstM",  64'(bus.W_dstM),  64'(mw_dstM));
    check_value("W_valE",  bus.W_valE,       mw_valE);
    check_value("W_valM",  bus.W_valM,       mw_valM);
    check_value($sformatf("rvalA[%0d]", bus.d_srcA), bus.d_rvalA, model_read(bus.d_srcA));
    check_value($sformatf("rvalB[%0d]", bus.d_srcB), bus.d_rvalB, model_read(bus.d_srcB));
  endtask

  // One clock: inputs are already applied; outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic [3:0] st, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic stall, input logic bubble);
    bus.m_stat   = st;
    bus.M_icode  = 4'h6;
    bus.M_valE   = ve;
    bus.m_valM   = vm;
    bus.M_dstE   = de;
    bus.M_dstM   = dm;
    bus.W_stall  = stall;
    bus.W_bubble = bubble;
  endtask

  // Reset pulse inside the low clock phase; every register is read while held.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #0.5;
    check_value("rst stat",   64'(bus.stat),   64'd1);
    check_value("rst halted", 64'(bus.halted), 64'd0);
    check_value("rst W_dstE", 64'(bus.W_dstE), 64'hF);
    for (int i = 0; i < 15; i++) begin
      bus.d_srcA = 4'(i);
      #0.5;
      check_value($sformatf("rst reg[%0d]", i), bus.d_rvalA, 64'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n = 1'b1;
    drive(4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    bus.d_srcA = 4'd0;
    bus.d_srcB = 4'hF;
    @(negedge clk);
    do_reset();

    // Single E-port write, then bubble to commit it.
    drive(4'd1, 64'h55, 64'h0, 4'd3, 4'hF, 1'b0, 1'b0);
    bus.d_srcA = 4'd3;
    cycle();
    drive(4'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1);
    cycle();
    check_value("reg3 after write", bus.d_rvalA, 64'h55);

    // Same destination on both ports: M port wins.
    drive(4'd1, 64'h11, 64'h22, 4'd5, 4'd5, 1'b0, 1'b0);
    bus.d_srcA = 4'd5;
    cycle();
    drive(4'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1);
    cycle();
    check_value("reg5 M priority", bus.d_rvalA, 64'h22);

    // Stall beats bubble; held W keeps rewriting reg6.
    drive(4'd1, 64'h7, 64'h0, 4'd6, 4'hF, 1'b0, 1'b0);
    bus.d_srcA = 4'd6;
    bus.d_srcB = 4'd9;
    cycle();
    drive(4'd1, 64'h1, 64'h0, 4'd9, 4'hF, 1'b1, 1'b1);
    repeat (3) cycle();
    check_value("stall W_dstE held", 64'(bus.W_dstE), 64'd6);
    drive(4'd1, 64'h1, 64'h0, 4'd9, 4'hF, 1'b0, 1'b0);
    cycle();
    check_value("post-stall capture", 64'(bus.W_dstE), 64'd9);

    // Reset with a pending write in W discards it.
    drive(4'd1, 64'hAA, 64'h0, 4'd2, 4'hF, 1'b0, 1'b0);
    cycle();
    do_reset();
    drive(4'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    bus.d_srcA = 4'd2;
    cycle();
    check_value("reg2 after reset", bus.d_rvalA, 64'd0);

    // HLT instruction: no commit of its own destination, sticky halt.
    drive(4'd2, 64'h99, 64'h0, 4'd4, 4'hF, 1'b0, 1'b0);
    bus.d_srcA = 4'd4;
    bus.d_srcB = 4'd1;
    cycle();
    drive(4'd1, 64'h123, 64'h0, 4'd1, 4'hF, 1'b0, 1'b0);
    cycle();
    check_value("halt stat", 64'(bus.stat), 64'd2);
    check_value("halt flag", 64'(bus.halted), 64'd1);
    repeat (3) cycle();
    check_value("reg4 not written", bus.d_rvalA, 64'd0);
    check_value("reg1 not written", bus.d_rvalB, 64'd0);
    do_reset();

    // Randomized traffic with occasional faults and periodic resets.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] st, de, dm;
      st = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      de = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dm = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 5) == 0) dm = de;
      drive(st, {$urandom, $urandom}, {$urandom, $urandom}, de, dm,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      bus.M_icode = 4'($urandom_range(0, 15));
      bus.d_srcA  = 4'($urandom_range(0, 15));
      bus.d_srcB  = 4'($urandom_range(0, 15));
      cycle();
      if ((n % 97) == 96) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have: clk  in  1  single clock; all state updates on posedge.
REQ-002 The block SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have: m_stat  in  4  memory-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-004 The block SHALL have: M_icode  in  4  memory-stage instruction code.
REQ-005 The block SHALL have: M_valE / m_valM  in  64 each  ALU result / memory read data.
REQ-006 The block SHALL have: M_dstE / M_dstM  in  4 each  destination register IDs; 4'hF = RNONE.
REQ-007 The block SHALL have: W_stall / W_bubble  in  1 each  pipeline-register hold / insert-NOP controls.
REQ-008 The block SHALL have: d_srcA / d_srcB  in  4 each  decode read addresses.
REQ-009 The block SHALL have: d_rvalA / d_rvalB  out  64 each  decode read data.
REQ-010 The block SHALL have: W_icode, W_dstE, W_dstM, W_valE, W_valM  out  4/4/4/64/64  W register contents for decode forwarding.
REQ-011 The block SHALL have: stat  out  4  processor status; halted  out  1  sticky halt flag.

Function
REQ-012 W register SHALL capture m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM on posedge when state RUN and W_stall=0 and W_bubble=0.
REQ-013 W_bubble=1 (W_stall=0) SHALL load stat=AOK, icode=NOP (4'h1), dstE=dstM=4'hF, valE=valM=0.
REQ-014 W_stall=1 SHALL hold W unchanged; stall wins over simultaneous bubble.
REQ-015 Register file SHALL hold 15 x 64-bit registers, IDs 0-14.
REQ-016 On posedge in state RUN with W stat=AOK: write W_valE to reg[W_dstE] if W_dstE!=F; write W_valM to reg[W_dstM] if W_dstM!=F.
REQ-017 If W_dstE==W_dstM!=F, W_valM SHALL be written (M port priority).
REQ-018 Write latency: data captured into W at edge N SHALL be in the register file after edge N+1.
REQ-019 Reads SHALL be combinational; srcX=F SHALL return 0.
REQ-020 State machine SHALL have two states: RUN, HALT.
REQ-021 RUN->HALT at posedge when W stat!=AOK; stat output SHALL latch that W stat; halted=1.
REQ-022 In HALT: no register writes, W frozen regardless of stall/bubble, stat/halted held; exit only by reset.
REQ-023 In RUN, stat output SHALL equal W stat (AOK after bubble); halted=0.
REQ-024 Instruction carrying non-AOK stat SHALL not write any register (including its own dstE/dstM).

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all 15 registers to 0, W to bubble values (REQ-013), state to RUN, stat=AOK, halted=0.
REQ-026 Reset asserted mid-operation (including in HALT or with a write pending in W) SHALL discard the pending write; first capture occurs on first posedge with rst_n=1.

Configuration
REQ-027 Macro WB_BYPASS_EN defined: if d_srcX!=F matches a register written this cycle per REQ-016/017, d_rvalX SHALL return the value being written (write-before-read).
REQ-028 Macro WB_BYPASS_EN undefined: d_rvalX SHALL return the stored value only; new value visible the cycle after the write edge.

Verification
REQ-029 Reset, then read srcA=0..14 -> d_rvalA=0 for all; stat=1; halted=0.
REQ-030 M_dstE=3, M_valE=0x55 at edge 1, bubble at edge 2 -> reg[3]=0x55 after edge 2; d_srcA=3 gives 0x55 (same cycle as edge-2 write only with WB_BYPASS_EN).
REQ-031 M_dstE=M_dstM=5, M_valE=0x11, m_valM=0x22 -> reg[5]=0x22.
REQ-032 m_stat=2 (HLT) with M_dstE=4, M_valE=0x99 -> after edge 2 stat=2, halted=1, reg[4]=0; further inputs with dstE=1 leave reg[1]=0.
REQ-033 W_stall=1 and W_bubble=1 for 3 cycles while W holds dstE=6, valE=7 -> W unchanged, reg[6] rewritten with 7 each edge; deassert -> next capture proceeds.
REQ-034 rst_n pulsed low mid-cycle with W holding dstE=2, valE=0xAA -> reg[2]=0 immediately, stays 0 after next edge.
